imem_load_controller: RTL and testbench

- Sequences the single-port, word-addressed instruction memory (256 x 32, indexed by byte address bits [9:2]) between two phases:
  - LOAD: an external loader streams program words into memory while the CPU is stalled.
  - RUN: the CPU fetch address passes straight through to the memory read port.
- Sits between the single-cycle CPU fetch stage, the instruction memory and the host/debug loader.
- Issues a one-cycle PC restart after every completed load.

---
 rtl/imem_load_controller.sv | 124 ++++++++++++
 tb/tb_imem_load_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_controller.sv
// Instruction-memory sequencer: streams a program image from the loader into the
// single-port IMEM while the CPU is stalled, then hands the read port to CPU fetch.
module imem_load_controller #(
  parameter int unsigned AW            = 8,
  parameter bit          BOOT_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic [31:0]   cpu_addr,
  output logic [31:0]   cpu_instr,
  output logic          cpu_stall,
  output logic          cpu_restart,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [AW:0]   load_count,
  output logic          load_err
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_DONE = 2'd1,
    S_RUN  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam state_t      RESET_STATE = BOOT_ON_RESET ? S_LOAD : S_RUN;
  localparam logic [AW:0] COUNT_MAX   = {1'b1, {AW{1'b0}}};

  state_t        state, state_next;
  logic [AW-1:0] wr_ptr, wr_ptr_next;
  logic [AW:0]   count_next;
  logic          err_next;

  // Only the word-index bits of the PC select an instruction.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:AW+2], cpu_addr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RESET_STATE;
      wr_ptr     <= '0;
      load_count <= '0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_next;
      wr_ptr     <= wr_ptr_next;
      load_count <= count_next;
      load_err   <= err_next;
    end
  end

  always_comb begin
    state_next  = state;
    wr_ptr_next = wr_ptr;
    count_next  = load_count;
    err_next    = load_err;
    ld_ready    = 1'b0;
    cpu_stall   = 1'b1;
    cpu_instr   = '0;
    cpu_restart = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = wr_ptr;
    mem_wdata   = ld_data;

    case (state)
      S_LOAD: begin
        ld_ready = 1'b1;
        mem_we   = ld_valid;
        // A restart request wins over bookkeeping: a same-cycle word is still
        // written at the old pointer, but progress is discarded.
        if (load_start) begin
          wr_ptr_next = '0;
          count_next  = '0;
        end else if (ld_valid) begin
          wr_ptr_next = wr_ptr + AW'(1);
          if (load_count != COUNT_MAX)
            count_next = load_count + (AW+1)'(1);
          if (ld_last) begin
            state_next = S_DONE;
          end else if (wr_ptr == '1) begin
            state_next = S_ERR;
            err_next   = 1'b1;
          end
        end
      end

      S_DONE: begin
        cpu_restart = 1'b1;
        state_next  = S_RUN;
      end

      S_RUN: begin
        cpu_stall = 1'b0;
        mem_addr  = cpu_addr[AW+1:2];
        cpu_instr = mem_rdata;
        if (load_start) begin
          state_next  = S_LOAD;
          wr_ptr_next = '0;
          count_next  = '0;
          err_next    = 1'b0;
        end
      end

      S_ERR: begin
        if (load_start) begin
          state_next  = S_LOAD;
          wr_ptr_next = '0;
          count_next  = '0;
          err_next    = 1'b0;
        end
      end

      default: state_next = RESET_STATE;
    endcase
  end

endmodule

// File: tb/tb_imem_load_controller.sv
// Bench for imem_load_controller: a behavioural IMEM plus a write scoreboard that
// expects each loader word at the index the bench tracks on its own.
module tb_imem_load_controller;

  localparam int unsigned AW = 8;

  logic          clk;
  logic          reset;
  logic          load_start;
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_instr;
  logic          cpu_stall;
  logic          cpu_restart;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [AW:0]   load_count;
  logic          load_err;

  imem_load_controller #(.AW(AW), .BOOT_ON_RESET(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .cpu_addr   (cpu_addr),
    .cpu_instr  (cpu_instr),
    .cpu_stall  (cpu_stall),
    .cpu_restart(cpu_restart),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .load_count (load_count),
    .load_err   (load_err)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] tb_mem [2**AW];
  logic [31:0] prog [12];
  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned exp_ptr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rdata = tb_mem[mem_addr];

  always @(posedge clk)
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write monitor: every mem_we cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (reset && mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'(mem_addr), 32'hffff_ffff);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", mem_wdata, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] data, input logic last);
    wr_t e;
    e.addr = exp_ptr[AW-1:0];
    e.data = data;
    exp_q.push_back(e);
    exp_ptr++;
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic pulse_load_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    exp_ptr    = 0;
  endtask

  // Called right after the handshake of the final word.
  task automatic expect_done_then_run(input int unsigned cnt);
    @(negedge clk);
    check("done_restart", 32'(cpu_restart), 32'd1);
    check("done_stall", 32'(cpu_stall), 32'd1);
    check("done_ready", 32'(ld_ready), 32'd0);
    check("done_instr", cpu_instr, 32'd0);
    step();
    @(negedge clk);
    check("run_restart", 32'(cpu_restart), 32'd0);
    check("run_stall", 32'(cpu_stall), 32'd0);
    check("run_count", 32'(load_count), 32'(cnt));
    step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_ptr = 0;
    for (int i = 0; i < 2**AW; i++) tb_mem[i] = '0;
    for (int i = 0; i < 12; i++) prog[i] = 32'h1000_0000 + 32'(i * 32'h0101);
    prog[0]  = 32'h2004_2f5b;
    prog[6]  = 32'h00c4_4020;
    prog[11] = 32'h0800_000b;

    reset      = 1'b0;
    load_start = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = '0;
    ld_last    = 1'b0;
    cpu_addr   = '0;

    #3;
    check("rst_stall", 32'(cpu_stall), 32'd1);
    check("rst_ready", 32'(ld_ready), 32'd1);
    check("rst_restart", 32'(cpu_restart), 32'd0);
    check("rst_count", 32'(load_count), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    #9 reset = 1'b1;
    step();

    // 12-word program on consecutive cycles
    for (int i = 0; i < 12; i++) send_word(prog[i], i == 11);
    expect_done_then_run(12);

    // Combinational fetch path
    cpu_addr = 32'h0000_0018;
    #1;
    check("fetch_addr", 32'(mem_addr), 32'd6);
    check("fetch_instr", cpu_instr, 32'h00c4_4020);
    cpu_addr = 32'h0000_001b;
    #1;
    check("fetch_addr_lsb", 32'(mem_addr), 32'd6);
    cpu_addr = 32'hffff_fc2c;
    #1;
    check("fetch_addr_hi", 32'(mem_addr), 32'd11);
    check("fetch_instr_hi", cpu_instr, 32'h0800_000b);
    ld_valid = 1'b1;
    #1;
    check("run_no_we", 32'(mem_we), 32'd0);
    step();
    ld_valid = 1'b0;

    // Reload from RUN with a 1-word program
    pulse_load_start();
    @(negedge clk);
    check("reload_stall", 32'(cpu_stall), 32'd1);
    check("reload_instr", cpu_instr, 32'd0);
    check("reload_count", 32'(load_count), 32'd0);
    step();
    send_word(32'h1234_5678, 1'b1);
    expect_done_then_run(1);
    cpu_addr = 32'h0;
    #1;
    check("one_word_fetch", cpu_instr, 32'h1234_5678);

    // Bubbles between words 3 and 4
    pulse_load_start();
    for (int i = 0; i < 4; i++) send_word(32'hb000_0000 + 32'(i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("gap_we", 32'(mem_we), 32'd0);
      check("gap_count", 32'(load_count), 32'd4);
      step();
    end
    for (int i = 4; i < 8; i++) send_word(32'hb000_0000 + 32'(i), i == 7);
    expect_done_then_run(8);

    // Overflow: 256 words with no ld_last
    pulse_load_start();
    for (int i = 0; i < 2**AW; i++) send_word(32'hc000_0000 + 32'(i), 1'b0);
    @(negedge clk);
    check("err_flag", 32'(load_err), 32'd1);
    check("err_stall", 32'(cpu_stall), 32'd1);
    check("err_ready", 32'(ld_ready), 32'd0);
    check("err_count", 32'(load_count), 32'd256);
    check("no_wrap_idx0", tb_mem[0], 32'hc000_0000);
    ld_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("err_no_we", 32'(mem_we), 32'd0);
      step();
    end
    ld_valid = 1'b0;
    @(negedge clk);
    check("err_sticky", 32'(load_err), 32'd1);
    step();
    pulse_load_start();
    @(negedge clk);
    check("err_clear", 32'(load_err), 32'd0);
    check("err_reload_cnt", 32'(load_count), 32'd0);
    step();
    send_word(32'hd00d_0001, 1'b1);
    expect_done_then_run(1);

    // Asynchronous reset in the middle of a load
    pulse_load_start();
    for (int i = 0; i < 5; i++) send_word(32'he000_0000 + 32'(i), 1'b0);
    #2 reset = 1'b0;
    #1;
    check("arst_count", 32'(load_count), 32'd0);
    check("arst_err", 32'(load_err), 32'd0);
    check("arst_stall", 32'(cpu_stall), 32'd1);
    check("arst_restart", 32'(cpu_restart), 32'd0);
    check("arst_ready", 32'(ld_ready), 32'd1);
    check("arst_addr", 32'(mem_addr), 32'd0);
    #10 reset = 1'b1;
    exp_ptr = 0;
    step();
    send_word(32'hf000_0000, 1'b0);
    send_word(32'hf000_0001, 1'b1);
    expect_done_then_run(2);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
